// File: rtl/dino_pkg.sv
// Shared types and sizing for the Dino Run game sequencer slice.
package dino_pkg;

   typedef enum logic [1:0] {
      ST_ATTRACT = 2'd0,
      ST_RUN     = 2'd1,
      ST_DYING   = 2'd2,
      ST_OVER    = 2'd3
   } game_state_t;

   localparam int unsigned DINO_SPEED_W = 4;
   localparam int unsigned SCORE_DIGITS = 3;
   localparam int unsigned SCORE_W      = 4 * SCORE_DIGITS;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Control/status bundle between the game sequencer and the rest of the game.
interface dino_game_ctrl_if;
   import dino_pkg::*;

   logic                    start_btn;
   logic                    collision;
   logic [3:0]              wrap_vec;
   game_state_t             state;
   logic                    play_reset;
   logic                    motion_tick;
   logic [DINO_SPEED_W-1:0] speed;
   logic [1:0]              anim_phase;
   logic [SCORE_W-1:0]      score_bcd;
   logic [SCORE_W-1:0]      hi_score_bcd;

   modport master (
      input  start_btn, collision, wrap_vec,
      output state, play_reset, motion_tick, speed, anim_phase, score_bcd, hi_score_bcd
   );

   modport slave (
      output start_btn, collision, wrap_vec,
      input  state, play_reset, motion_tick, speed, anim_phase, score_bcd, hi_score_bcd
   );

endinterface

// File: rtl/dino_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; wrap_o flags the all-nines rollover.
module dino_bcd_counter
   import dino_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr_i,
   input  logic               inc_i,
   output logic [SCORE_W-1:0] count_o,
   output logic               wrap_o
);

   logic [SCORE_W-1:0] count_q, count_d;
   logic               carry;

   // Ripple the increment up through the digits; a digit at 9 rolls to 0 and passes the carry on.
   always_comb begin
      count_d = count_q;
      carry   = inc_i;
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
         if (carry) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               count_d[4*i +: 4] = 4'd0;
            end else begin
               count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
      wrap_o = carry & ~clr_i;
      if (clr_i) count_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino Run game sequencer: phase FSM, motion-tick divider, start-button sync, speed and scores.
module dino_game_ctrl
   import dino_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 2_000_000,
   parameter int unsigned PASS_PER_LEVEL = 12,
   parameter int unsigned MAX_SPEED      = 8,
   parameter int unsigned DYING_TICKS    = 32
)
(
   input  logic               clk,
   input  logic               reset,
   dino_game_ctrl_if.master   bus
);

   localparam int unsigned DIV_W   = $clog2(TICK_DIV);
   localparam int unsigned DYING_W = (DYING_TICKS > 1) ? $clog2(DYING_TICKS) : 1;

   localparam logic [DIV_W-1:0]        DIV_LAST   = DIV_W'(TICK_DIV - 1);
   localparam logic [DYING_W-1:0]      DYING_LAST = DYING_W'(DYING_TICKS - 1);
   localparam logic [5:0]              PASS_LVL   = 6'(PASS_PER_LEVEL);
   localparam logic [DINO_SPEED_W-1:0] SPEED_MAX  = DINO_SPEED_W'(MAX_SPEED);
   localparam logic [DINO_SPEED_W-1:0] SPEED_ONE  = DINO_SPEED_W'(1);

   logic                    sync1_q, sync2_q, prev_q;
   logic                    btn_rise;
   game_state_t             state_q, state_d;
   logic                    play_reset_q, play_reset_d;
   logic                    motion_tick_q, motion_tick_d;
   logic [DINO_SPEED_W-1:0] speed_q, speed_d;
   logic [1:0]              anim_q, anim_d;
   logic [4:0]              pass_q, pass_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [DYING_W-1:0]      dying_q, dying_d;
   logic [SCORE_W-1:0]      hi_q, hi_d;
   logic [SCORE_W-1:0]      score;
   logic                    score_clr, score_inc;
   logic                    div_last;
   logic [5:0]              pass_sum;

   assign btn_rise = sync2_q & ~prev_q;
   assign div_last = (div_q == DIV_LAST);
   assign pass_sum = {1'b0, pass_q} + {3'b000, popcount4(bus.wrap_vec)};

   dino_bcd_counter u_score (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (score_clr),
      .inc_i   (score_inc),
      .count_o (score),
      .wrap_o  ()
   );

   always_comb begin
      state_d       = state_q;
      play_reset_d  = 1'b0;
      motion_tick_d = 1'b0;
      speed_d       = speed_q;
      anim_d        = anim_q;
      pass_d        = pass_q;
      div_d         = div_q;
      dying_d       = dying_q;
      hi_d          = hi_q;
      score_clr     = 1'b0;
      score_inc     = 1'b0;

      unique case (state_q)
         ST_ATTRACT, ST_OVER: begin
            div_d = '0;
            if (btn_rise) begin
               state_d      = ST_RUN;
               play_reset_d = 1'b1;
               score_clr    = 1'b1;
               speed_d      = SPEED_ONE;
               pass_d       = '0;
               anim_d       = '0;
            end
         end

         ST_RUN: begin
            // Collision wins over a coincident tick: that tick is simply never issued.
            if (bus.collision) begin
               state_d = ST_DYING;
               div_d   = '0;
               dying_d = '0;
               if (score > hi_q) hi_d = score;
            end else if (div_last) begin
               div_d         = '0;
               motion_tick_d = 1'b1;
               score_inc     = 1'b1;
               anim_d        = anim_q + 2'd1;
               if (pass_sum >= PASS_LVL) begin
                  pass_d = 5'(pass_sum - PASS_LVL);
                  if (speed_q < SPEED_MAX) speed_d = speed_q + 1'b1;
               end else begin
                  pass_d = pass_sum[4:0];
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         ST_DYING: begin
            if (div_last) begin
               div_d = '0;
               if (dying_q == DYING_LAST) state_d = ST_OVER;
               else                       dying_d = dying_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end

         default: state_d = ST_ATTRACT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         prev_q        <= 1'b0;
         state_q       <= ST_ATTRACT;
         play_reset_q  <= 1'b0;
         motion_tick_q <= 1'b0;
         speed_q       <= SPEED_ONE;
         anim_q        <= '0;
         pass_q        <= '0;
         div_q         <= '0;
         dying_q       <= '0;
         hi_q          <= '0;
      end else begin
         sync1_q       <= bus.start_btn;
         sync2_q       <= sync1_q;
         prev_q        <= sync2_q;
         state_q       <= state_d;
         play_reset_q  <= play_reset_d;
         motion_tick_q <= motion_tick_d;
         speed_q       <= speed_d;
         anim_q        <= anim_d;
         pass_q        <= pass_d;
         div_q         <= div_d;
         dying_q       <= dying_d;
         hi_q          <= hi_d;
      end
   end

   assign bus.state        = state_q;
   assign bus.play_reset   = play_reset_q;
   assign bus.motion_tick  = motion_tick_q;
   assign bus.speed        = speed_q;
   assign bus.anim_phase   = anim_q;
   assign bus.score_bcd    = score;
   assign bus.hi_score_bcd = hi_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed self-checking bench for dino_game_ctrl with a 4-cycle motion tick.
module tb_dino_game_ctrl;
   import dino_pkg::*;

   localparam int unsigned TB_TICK = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ticks    = 0;

   dino_game_ctrl_if dif ();

   dino_game_ctrl #(
      .TICK_DIV       (TB_TICK),
      .PASS_PER_LEVEL (12),
      .MAX_SPEED      (8),
      .DYING_TICKS    (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.master)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] to_bcd(input int unsigned v);
      logic [3:0] h, t, u;
      h = 4'((v / 100) % 10);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   task automatic wait_tick();
      int c = 0;
      do begin
         step();
         c++;
      end while (!dif.motion_tick && c < 16);
      n_checks++;
      if (c !== TB_TICK) begin n_fail++; $display("FAIL tick_period: got %0d cycles, expected %0d", c, TB_TICK); end
      ticks++;
   endtask

   task automatic test_reset();
      int bad = 0;
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (dif.motion_tick !== 1'b0 || dif.play_reset !== 1'b0 || dif.state !== ST_ATTRACT) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_attract: got %0d bad cycles, expected 0", bad); end
      n_checks++; if (dif.speed !== 4'd1) begin n_fail++; $display("FAIL reset_speed: got %0d expected 1", dif.speed); end
      n_checks++; if (dif.anim_phase !== 2'd0) begin n_fail++; $display("FAIL reset_anim: got %0d expected 0", dif.anim_phase); end
      n_checks++; if (dif.score_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_score: got %h expected 000", dif.score_bcd); end
      n_checks++; if (dif.hi_score_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_hi: got %h expected 000", dif.hi_score_bcd); end
   endtask

   task automatic test_start();
      dif.start_btn = 1'b1;
      step();
      n_checks++; if (dif.play_reset !== 1'b0 || dif.state !== ST_ATTRACT) begin n_fail++; $display("FAIL start_edgeN: got pr=%b st=%0d expected pr=0 st=0", dif.play_reset, dif.state); end
      step();
      n_checks++; if (dif.play_reset !== 1'b0 || dif.state !== ST_ATTRACT) begin n_fail++; $display("FAIL start_edgeN1: got pr=%b st=%0d expected pr=0 st=0", dif.play_reset, dif.state); end
      step();
      n_checks++; if (dif.play_reset !== 1'b1 || dif.state !== ST_RUN) begin n_fail++; $display("FAIL start_edgeN2: got pr=%b st=%0d expected pr=1 st=1", dif.play_reset, dif.state); end
      n_checks++; if (dif.motion_tick !== 1'b0) begin n_fail++; $display("FAIL start_no_tick: got %b expected 0", dif.motion_tick); end
   endtask

   task automatic test_run_ticks();
      int nt = 0, npr = 0, misplaced = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (dif.play_reset) npr++;
         if (dif.motion_tick) nt++;
         if (dif.motion_tick !== ((k % TB_TICK) == 0)) misplaced++;
      end
      dif.start_btn = 1'b0;
      ticks = 10;
      n_checks++; if (nt !== 10) begin n_fail++; $display("FAIL run_tick_count: got %0d expected 10", nt); end
      n_checks++; if (misplaced !== 0) begin n_fail++; $display("FAIL run_tick_phase: got %0d misplaced expected 0", misplaced); end
      n_checks++; if (npr !== 0) begin n_fail++; $display("FAIL held_btn_retrigger: got %0d play_resets expected 0", npr); end
      n_checks++; if (dif.score_bcd !== 12'h010) begin n_fail++; $display("FAIL run_score: got %h expected 010", dif.score_bcd); end
      n_checks++; if (dif.anim_phase !== 2'd2) begin n_fail++; $display("FAIL run_anim: got %0d expected 2", dif.anim_phase); end
   endtask

   task automatic test_speed();
      int bad = 0;
      dif.wrap_vec = 4'b1111;
      wait_tick(); wait_tick();
      n_checks++; if (dif.speed !== 4'd1) begin n_fail++; $display("FAIL speed_at8: got %0d expected 1", dif.speed); end
      wait_tick();
      n_checks++; if (dif.speed !== 4'd2) begin n_fail++; $display("FAIL speed_at12: got %0d expected 2", dif.speed); end
      // wraps presented only on non-tick cycles must not count
      for (int p = 0; p < 3; p++) begin
         dif.wrap_vec = 4'b1111;
         step();
         dif.wrap_vec = 4'b0000;
         repeat (3) step();
         if (dif.motion_tick !== 1'b1) bad++;
         ticks++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL offtick_period: got %0d bad expected 0", bad); end
      n_checks++; if (dif.speed !== 4'd2) begin n_fail++; $display("FAIL speed_offtick_wrap: got %0d expected 2", dif.speed); end
      dif.wrap_vec = 4'b1111;
      repeat (3) wait_tick();
      n_checks++; if (dif.speed !== 4'd3) begin n_fail++; $display("FAIL speed_pass_reset: got %0d expected 3", dif.speed); end
      repeat (100) wait_tick();
      n_checks++; if (dif.speed !== 4'd8) begin n_fail++; $display("FAIL speed_saturate: got %0d expected 8", dif.speed); end
      dif.wrap_vec = 4'b0000;
   endtask

   task automatic test_score_wrap();
      while (ticks < 999) wait_tick();
      n_checks++; if (dif.score_bcd !== 12'h999) begin n_fail++; $display("FAIL score_999: got %h expected 999", dif.score_bcd); end
      wait_tick();
      n_checks++; if (dif.score_bcd !== 12'h000) begin n_fail++; $display("FAIL score_wrap: got %h expected 000", dif.score_bcd); end
      n_checks++; if (dif.state !== ST_RUN) begin n_fail++; $display("FAIL wrap_state: got %0d expected 1", dif.state); end
   endtask

   task automatic test_collision();
      int bad = 0;
      repeat (5) wait_tick();
      n_checks++; if (dif.score_bcd !== to_bcd(ticks)) begin n_fail++; $display("FAIL pre_collide_score: got %h expected %h", dif.score_bcd, to_bcd(ticks)); end
      repeat (3) step();
      dif.collision = 1'b1;
      step();
      dif.collision = 1'b0;
      n_checks++; if (dif.state !== ST_DYING) begin n_fail++; $display("FAIL collide_state: got %0d expected 2", dif.state); end
      n_checks++; if (dif.motion_tick !== 1'b0) begin n_fail++; $display("FAIL collide_tick_dropped: got %b expected 0", dif.motion_tick); end
      n_checks++; if (dif.score_bcd !== 12'h005) begin n_fail++; $display("FAIL collide_score: got %h expected 005", dif.score_bcd); end
      n_checks++; if (dif.hi_score_bcd !== 12'h005) begin n_fail++; $display("FAIL collide_hi: got %h expected 005", dif.hi_score_bcd); end
      for (int k = 1; k <= 11; k++) begin
         if (k == 2) dif.start_btn = 1'b1;
         if (k == 5) dif.start_btn = 1'b0;
         step();
         if (dif.state !== ST_DYING || dif.motion_tick !== 1'b0 || dif.play_reset !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL dying_hold: got %0d bad cycles expected 0", bad); end
      step();
      n_checks++; if (dif.state !== ST_OVER) begin n_fail++; $display("FAIL dying_to_over: got %0d expected 3", dif.state); end
      bad = 0;
      repeat (10) begin
         step();
         if (dif.state !== ST_OVER || dif.score_bcd !== 12'h005 || dif.speed !== 4'd8 || dif.motion_tick !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL over_frozen: got %0d bad cycles expected 0", bad); end
   endtask

   task automatic test_restart();
      dif.start_btn = 1'b1;
      repeat (3) step();
      dif.start_btn = 1'b0;
      n_checks++; if (dif.play_reset !== 1'b1 || dif.state !== ST_RUN) begin n_fail++; $display("FAIL restart_pulse: got pr=%b st=%0d expected pr=1 st=1", dif.play_reset, dif.state); end
      n_checks++; if (dif.score_bcd !== 12'h000 || dif.speed !== 4'd1 || dif.anim_phase !== 2'd0) begin n_fail++; $display("FAIL restart_clear: got score=%h speed=%0d anim=%0d expected 000/1/0", dif.score_bcd, dif.speed, dif.anim_phase); end
      n_checks++; if (dif.hi_score_bcd !== 12'h005) begin n_fail++; $display("FAIL restart_hi_kept: got %h expected 005", dif.hi_score_bcd); end
      ticks = 0;
      wait_tick(); wait_tick();
      dif.collision = 1'b1;
      step();
      dif.collision = 1'b0;
      n_checks++; if (dif.state !== ST_DYING || dif.score_bcd !== 12'h002) begin n_fail++; $display("FAIL second_collide: got st=%0d score=%h expected 2/002", dif.state, dif.score_bcd); end
      n_checks++; if (dif.hi_score_bcd !== 12'h005) begin n_fail++; $display("FAIL hi_not_lowered: got %h expected 005", dif.hi_score_bcd); end
      repeat (12) step();
      n_checks++; if (dif.state !== ST_OVER) begin n_fail++; $display("FAIL second_over: got %0d expected 3", dif.state); end
   endtask

   task automatic test_reset_mid();
      dif.start_btn = 1'b1;
      repeat (3) step();
      dif.start_btn = 1'b0;
      n_checks++; if (dif.state !== ST_RUN) begin n_fail++; $display("FAIL third_start: got %0d expected 1", dif.state); end
      repeat (3) wait_tick();
      #2 reset = 1'b1;
      #1;
      n_checks++; if (dif.state !== ST_ATTRACT || dif.motion_tick !== 1'b0 || dif.play_reset !== 1'b0) begin n_fail++; $display("FAIL async_reset_state: got st=%0d mt=%b pr=%b expected 0/0/0", dif.state, dif.motion_tick, dif.play_reset); end
      n_checks++; if (dif.hi_score_bcd !== 12'h000 || dif.score_bcd !== 12'h000) begin n_fail++; $display("FAIL async_reset_scores: got hi=%h score=%h expected 000/000", dif.hi_score_bcd, dif.score_bcd); end
      n_checks++; if (dif.speed !== 4'd1 || dif.anim_phase !== 2'd0) begin n_fail++; $display("FAIL async_reset_speed: got speed=%0d anim=%0d expected 1/0", dif.speed, dif.anim_phase); end
      repeat (2) step();
      reset = 1'b0;
      repeat (2) step();
      n_checks++; if (dif.state !== ST_ATTRACT) begin n_fail++; $display("FAIL post_reset_state: got %0d expected 0", dif.state); end
   endtask

   initial begin
      dif.start_btn = 1'b0;
      dif.collision = 1'b0;
      dif.wrap_vec  = 4'b0000;
      test_reset();
      test_start();
      test_run_ticks();
      test_speed();
      test_score_wrap();
      test_collision();
      test_restart();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Central game sequencer for Dino Run. It owns the game phase state machine (attract, run, dying, over) and the motion-tick divider, and generates the pulses that step obstacles, animation and the LFSR. It also keeps the BCD score, the high score and the speed level. It sits between the controller input and collision detector on one side and the obstacle/sprite datapath and VGA drawing logic on the other; the datapath consumes its pulses and registers and holds no game-phase logic of its own.

## Interface
- TICK_DIV, 2_000_000, clk cycles per motion tick (≥2)
- PASS_PER_LEVEL, 12, obstacle wraps per speed increment (1..31)
- MAX_SPEED, 8, speed saturation value (≤15)
- DYING_TICKS, 32, ticks spent in DYING before OVER (≥1)
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- start_btn  in  1  raw, asynchronous replay/start button (controller_report[4])
- collision  in  1  level from the collision detector, valid every cycle
- wrap_vec  in  4  one bit per obstacle (s_cac, group, lava, ptr); high in a tick cycle if that obstacle wrapped
- state  out  2  game_state_t
- play_reset  out  1  one-cycle pulse; datapath reloads obstacle start positions
- motion_tick  out  1  one-cycle pulse; datapath steps obstacles and the LFSR
- speed  out  4  obstacle step per tick
- anim_phase  out  2  sprite animation phase
- score_bcd  out  12  {hundreds, tens, units}
- hi_score_bcd  out  12  best score since reset

## Operation
- Reset values: state=ATTRACT, play_reset=0, motion_tick=0, speed=1, anim_phase=0, score_bcd=0, hi_score_bcd=0. Divider=0, pass_count=0, dying counter=0.
- start_btn input path:
  - Two flop synchronizer, then a previous-value flop.
  - btn_rise = sync2 & ~prev.
  - Only rising edges act. A held button does not retrigger.
- ATTRACT to RUN on btn_rise.
- OVER to RUN on btn_rise.
- On any entry to RUN, in the same cycle as the state change:
  - play_reset=1
  - score=0, speed=1, pass_count=0, anim_phase=0, divider=0
  - hi_score is kept.
- RUN:
  - The divider counts 0..TICK_DIV-1.
  - At TICK_DIV-1: motion_tick=1, divider returns to 0, score BCD +1 (999 wraps to 000), anim_phase +1 (wraps).
  - On a tick cycle, sum = pass_count + popcount(wrap_vec). If sum ≥ PASS_PER_LEVEL: pass_count = sum − PASS_PER_LEVEL and speed = min(speed+1, MAX_SPEED). Otherwise pass_count = sum.
  - wrap_vec is ignored on non-tick cycles.
- RUN to DYING when collision=1. Collision has priority over a tick in the same cycle: that tick is dropped (no motion_tick, no score or speed change).
- On entry to DYING:
  - divider=0, dying counter=0
  - hi_score = score if score > hi_score. Compare the 12-bit BCD as unsigned; this is order-preserving.
- DYING:
  - The divider runs and produces internal ticks. motion_tick stays 0.
  - After DYING_TICKS internal ticks, go to OVER.
  - btn_rise and collision are ignored.
- OVER: divider held at 0. score, speed and hi_score are frozen for display.
- Reset asserted mid-game returns everything to reset values immediately, including hi_score.

## Timing
- All outputs are registered.
- Button latency: the first clk edge that samples start_btn=1 is edge N. state=RUN and play_reset=1 during the cycle after edge N+2 (3 edges).
- First motion_tick after play_reset comes exactly TICK_DIV cycles after the play_reset cycle.
- motion_tick period in RUN is exactly TICK_DIV cycles. It is never high in the same cycle as play_reset.
- Collision latency: collision sampled high at edge M gives state=DYING after edge M.
- DYING lasts exactly DYING_TICKS×TICK_DIV cycles.

## Structure
- dino_pkg holds:
  - typedef enum logic [1:0] game_state_t {ST_ATTRACT=0, ST_RUN=1, ST_DYING=2, ST_OVER=3}
  - localparam DINO_SPEED_W=4
  - localparam SCORE_DIGITS=3
- One sub-module, dino_bcd_counter: 3-digit BCD counter with synchronous clear and increment enable, plus a wrap output.
- The synchronizer, divider, FSM and speed logic stay in dino_game_ctrl.

## Test plan
All scenarios use TICK_DIV=4, PASS_PER_LEVEL=12, MAX_SPEED=8, DYING_TICKS=3.
- Reset then idle 100 cycles: state=ATTRACT, no motion_tick, all outputs at reset values. Hold start_btn high: exactly one play_reset, 3 edges after the first sampling edge.
- RUN for 40 cycles: motion_tick every 4 cycles, 10 ticks total, score_bcd=0x010, anim_phase=2.
- Tick with wrap_vec=4'b1111 three times: 4, 8, then 12 gives speed=2, pass_count=0. Drive 100 more wraps: speed saturates at 8.
- Score 999 then one tick: score_bcd=0x000 and state stays RUN.
- Collision on the same cycle as a would-be tick: no motion_tick, score unchanged, state=DYING, hi_score_bcd updated. OVER is reached 12 cycles later. A btn_rise during DYING is ignored.
- In OVER, press start: play_reset pulses, score=0, speed=1, hi_score_bcd retained. Asserting reset mid-RUN clears hi_score_bcd to 0.
